sync_sp_ram_banked: RTL and testbench
=====================================

SYNC_SP_RAM_BANKED -- requirements
Module: sync_sp_ram_banked

Interface
REQ-001 SHALL have parameter DATA_W, default 64, word width in bits, legal range 1..128.
REQ-002 SHALL have parameter NUM_WORDS, default 256, depth, legal values multiples of 256 in the range 256..1024.
REQ-003 SHALL have parameter INIT_ZERO, default 1; when 1, all words are zeroed after reset.
REQ-004 SHALL derive ADDR_W = clog2(NUM_WORDS), BE_W = ceil(DATA_W/8), COLS = ceil(DATA_W/16) and BANKS = NUM_WORDS/256.
REQ-005 SHALL be single-clock with synchronous, active-high reset.
REQ-006 Clk_CI  in  1  clock; all logic is on the rising edge.
REQ-007 Rst_RI  in  1  synchronous active-high reset.
REQ-008 CSel_SI  in  1  request valid (chip select, active-high).
REQ-009 WrEn_SI  in  1  1 = write, 0 = read.
REQ-010 BEn_SI  in  BE_W  byte enables; bit b covers data bits [8b+7:8b].
REQ-011 WrData_DI  in  DATA_W  write data.
REQ-012 Addr_DI  in  ADDR_W  word address.
REQ-013 RdData_DO  out  DATA_W  read data.
REQ-014 RdValid_DO  out  1  one-cycle pulse; RdData_DO is updated in the same cycle.
REQ-015 Ready_SO  out  1  1 = requests are accepted.
REQ-016 InitDone_SO  out  1  one-cycle pulse when zero-init completes.
REQ-017 AddrErr_SO  out  1  one-cycle pulse, one cycle after an accepted request with Addr_DI >= NUM_WORDS.

Function
REQ-018 SHALL build storage from BANKS x COLS fakeram130_256x16 instances, driving ce_in and we_in active-low, addr_in = Addr_DI[7:0] and bank = Addr_DI[ADDR_W-1:8].
REQ-019 A request is accepted when CSel_SI=1 and Ready_SO=1; when Ready_SO=0, CSel_SI SHALL be ignored with no macro access and no pulses.
REQ-020 On an accepted in-range request, only the selected bank's macros SHALL have ce_in asserted.
REQ-021 Write: w_mask_in bit i = BEn_SI[i/8] for data bits i < DATA_W; padding bits have mask 0 and data 0; BEn_SI=0 writes nothing.
REQ-022 Read latency SHALL be 1 cycle: request accepted in cycle N gives RdValid_DO=1 in cycle N+1, with data selected by the bank index registered in cycle N.
REQ-023 RdData_DO SHALL hold its last value through writes, idle cycles and out-of-range accesses until the next RdValid_DO.
REQ-024 Back-to-back reads to different banks SHALL be supported every cycle, each returning the correct bank's data.
REQ-025 Out-of-range write SHALL be dropped; out-of-range read SHALL give RdValid_DO=1 with RdData_DO=0; both SHALL pulse AddrErr_SO.
REQ-026 A write followed by a read of the same address in the next cycle SHALL return the new data; there is no bypass need because the macro writes in the accept cycle.
REQ-027 FSM states: INIT and IDLE; reset enters INIT if INIT_ZERO=1, else IDLE.
REQ-028 INIT SHALL write zeros with a full mask to addr_in = counter in all banks and columns simultaneously, with the 8-bit counter running 0..255, one address per cycle.
REQ-029 INIT->IDLE SHALL occur after counter 255 is written; InitDone_SO pulses in the first IDLE cycle; init takes exactly 256 cycles.
REQ-030 Ready_SO SHALL be 0 in INIT and 1 in IDLE.
REQ-031 With INIT_ZERO=0, InitDone_SO SHALL pulse in the first cycle after reset deasserts.

Reset
REQ-032 With Rst_RI=1, outputs SHALL be: RdData_DO=0, RdValid_DO=0, AddrErr_SO=0, InitDone_SO=0, Ready_SO=0; all macros are deselected; the init counter is 0.
REQ-033 Reset asserted mid-INIT or mid-read SHALL restart INIT from address 0 and SHALL suppress the pending RdValid_DO.
REQ-034 Memory contents are not cleared by reset itself, only by INIT.

Verification
REQ-035 Default params, reset then idle -> Ready_SO=0 for 256 cycles, InitDone_SO pulses once, a read of addr 0x7F returns 0.
REQ-036 Write 0x0123456789ABCDEF to addr 5 with BEn=0xFF, then write 0xFFFF..FF with BEn=0x0F, read addr 5 -> 0x01234567FFFFFFFF, RdValid_DO exactly 1 cycle after the request.
REQ-037 DATA_W=45, NUM_WORDS=768: write 0x1FFFFFFFFFFF to addr 300 and 0x0AAAAAAAAAAA to addr 44, alternate reads every cycle -> correct data per bank, RdData_DO[44:0] only.
REQ-038 NUM_WORDS=768, read addr 800 -> RdValid_DO=1, RdData_DO=0, AddrErr_SO=1; a write to 800 leaves every in-range word unchanged.
REQ-039 Reset at INIT cycle 100 -> full 256-cycle INIT restarts; CSel_SI pulses during INIT cause no RdValid_DO.
REQ-040 Read in cycle N, then idle and a write in N+2 -> RdData_DO stable from N+1 until the next read.

Source files
------------

// File: rtl/sync_sp_ram_banked.sv
// Banked single-port RAM built from 256x16 macros, with optional zero-fill after reset.
// Latency: read data and RdValid_DO one cycle after an accepted request; writes land in the accept cycle.
// Backpressure: Ready_SO is low during zero-fill and reset; CSel_SI is ignored while it is low.

module fakeram130_256x16 (
  input  logic        clk,
  input  logic        ce_in,
  input  logic        we_in,
  input  logic [7:0]  addr_in,
  input  logic [15:0] wd_in,
  input  logic [15:0] w_mask_in,
  output logic [15:0] rd_out
);

  logic [15:0] mem [256];

  // Enables are active-low; a write leaves rd_out untouched.
  always_ff @(posedge clk) begin
    if (!ce_in) begin
      if (!we_in) begin
        mem[addr_in] <= (mem[addr_in] & ~w_mask_in) | (wd_in & w_mask_in);
      end else begin
        rd_out <= mem[addr_in];
      end
    end
  end

endmodule

module sync_sp_ram_banked #(
  parameter  int DATA_W    = 64,
  parameter  int NUM_WORDS = 256,
  parameter  int INIT_ZERO = 1,
  localparam int ADDR_W    = $clog2(NUM_WORDS),
  localparam int BE_W      = (DATA_W + 7) / 8
) (
  input  logic              Clk_CI,
  input  logic              Rst_RI,
  input  logic              CSel_SI,
  input  logic              WrEn_SI,
  input  logic [BE_W-1:0]   BEn_SI,
  input  logic [DATA_W-1:0] WrData_DI,
  input  logic [ADDR_W-1:0] Addr_DI,
  output logic [DATA_W-1:0] RdData_DO,
  output logic              RdValid_DO,
  output logic              Ready_SO,
  output logic              InitDone_SO,
  output logic              AddrErr_SO
);

  localparam int COLS  = (DATA_W + 15) / 16;
  localparam int BANKS = NUM_WORDS / 256;
  localparam int PAD_W = COLS * 16;
  localparam logic [ADDR_W-1:0] BANKS_A = ADDR_W'(BANKS);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                init_wr;

  logic [ADDR_W-1:0]   bank_idx;
  logic                in_range;
  logic                ready;
  logic                accept;

  logic                rd_vld_q;
  logic                rd_oor_q;
  logic                err_q;
  logic [ADDR_W-1:0]   bank_q;
  logic [DATA_W-1:0]   hold_q;

  logic [PAD_W-1:0]    wd_pad;
  logic [PAD_W-1:0]    wm_pad;
  logic [7:0]          mac_addr;
  logic                mac_we_n;
  logic [BANKS-1:0]    ce_n;
  logic [BANKS-1:0][PAD_W-1:0] bank_rd;

  logic [PAD_W-1:0]    rd_mux;
  logic [DATA_W-1:0]   rd_cur;
  logic                unused_rd_mux;

  assign bank_idx = Addr_DI >> 8;
  assign in_range = (bank_idx < BANKS_A);
  assign ready    = (state_q == ST_IDLE) && !Rst_RI;
  assign accept   = CSel_SI && ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    init_wr = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_wr = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        if (cnt_q == 8'hFF) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q  <= (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
      cnt_q    <= 8'd0;
      // Without zero-fill the done pulse lands in the first cycle out of reset.
      done_q   <= (INIT_ZERO == 0);
      rd_vld_q <= 1'b0;
      rd_oor_q <= 1'b0;
      err_q    <= 1'b0;
      bank_q   <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      rd_vld_q <= accept && !WrEn_SI;
      rd_oor_q <= !in_range;
      err_q    <= accept && !in_range;
      if (accept) begin
        bank_q <= bank_idx;
      end
      if (rd_vld_q) begin
        hold_q <= rd_cur;
      end
    end
  end

  // Zero-fill drives every bank at once; normal traffic selects one bank only.
  always_comb begin
    wd_pad   = '0;
    wm_pad   = '0;
    mac_addr = Addr_DI[7:0];
    mac_we_n = !WrEn_SI;
    ce_n     = '1;
    if (init_wr && !Rst_RI) begin
      wm_pad   = '1;
      mac_addr = cnt_q;
      mac_we_n = 1'b0;
      ce_n     = '0;
    end else begin
      for (int i = 0; i < DATA_W; i++) begin
        wd_pad[i] = WrData_DI[i];
        wm_pad[i] = BEn_SI[i/8];
      end
      for (int b = 0; b < BANKS; b++) begin
        if (accept && in_range && (bank_idx == ADDR_W'(b))) begin
          ce_n[b] = 1'b0;
        end
      end
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    for (genvar c = 0; c < COLS; c++) begin : g_col
      fakeram130_256x16 u_mac (
        .clk       (Clk_CI),
        .ce_in     (ce_n[b]),
        .we_in     (mac_we_n),
        .addr_in   (mac_addr),
        .wd_in     (wd_pad[c*16 +: 16]),
        .w_mask_in (wm_pad[c*16 +: 16]),
        .rd_out    (bank_rd[b][c*16 +: 16])
      );
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_q == ADDR_W'(b)) begin
        rd_mux = bank_rd[b];
      end
    end
  end

  assign unused_rd_mux = ^rd_mux;
  assign rd_cur        = rd_oor_q ? '0 : rd_mux[DATA_W-1:0];

  // Reset masks the outputs immediately, which also kills a read response in flight.
  assign RdData_DO   = Rst_RI ? '0 : (rd_vld_q ? rd_cur : hold_q);
  assign RdValid_DO  = rd_vld_q && !Rst_RI;
  assign AddrErr_SO  = err_q && !Rst_RI;
  assign InitDone_SO = done_q && !Rst_RI;
  assign Ready_SO    = ready;

endmodule

// File: tb/tb_sync_sp_ram_banked.sv
// Bench for sync_sp_ram_banked: three instances (64x256, 45x768, 16x512 without zero-fill)
// checked against a word-array model with byte-enable merge rules.
module tb_sync_sp_ram_banked;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [2:0]        rst, cs, we;
  logic [2:0][15:0]  be;
  logic [2:0][127:0] wd;
  logic [2:0][9:0]   ad;
  logic [63:0]       rd0;
  logic [44:0]       rd1;
  logic [15:0]       rd2;
  logic [2:0]        vld, rdy, done, err;

  logic [127:0] mem [3][1024];

  sync_sp_ram_banked #(.DATA_W(64), .NUM_WORDS(256), .INIT_ZERO(1)) u_d0 (
    .Clk_CI(clk), .Rst_RI(rst[0]), .CSel_SI(cs[0]), .WrEn_SI(we[0]), .BEn_SI(be[0][7:0]),
    .WrData_DI(wd[0][63:0]), .Addr_DI(ad[0][7:0]), .RdData_DO(rd0), .RdValid_DO(vld[0]),
    .Ready_SO(rdy[0]), .InitDone_SO(done[0]), .AddrErr_SO(err[0]));

  sync_sp_ram_banked #(.DATA_W(45), .NUM_WORDS(768), .INIT_ZERO(1)) u_d1 (
    .Clk_CI(clk), .Rst_RI(rst[1]), .CSel_SI(cs[1]), .WrEn_SI(we[1]), .BEn_SI(be[1][5:0]),
    .WrData_DI(wd[1][44:0]), .Addr_DI(ad[1][9:0]), .RdData_DO(rd1), .RdValid_DO(vld[1]),
    .Ready_SO(rdy[1]), .InitDone_SO(done[1]), .AddrErr_SO(err[1]));

  sync_sp_ram_banked #(.DATA_W(16), .NUM_WORDS(512), .INIT_ZERO(0)) u_d2 (
    .Clk_CI(clk), .Rst_RI(rst[2]), .CSel_SI(cs[2]), .WrEn_SI(we[2]), .BEn_SI(be[2][1:0]),
    .WrData_DI(wd[2][15:0]), .Addr_DI(ad[2][8:0]), .RdData_DO(rd2), .RdValid_DO(vld[2]),
    .Ready_SO(rdy[2]), .InitDone_SO(done[2]), .AddrErr_SO(err[2]));

  function automatic int dw(input int d);
    case (d)
      0: return 64;
      1: return 45;
      default: return 16;
    endcase
  endfunction

  function automatic int nw(input int d);
    case (d)
      0: return 256;
      1: return 768;
      default: return 512;
    endcase
  endfunction

  function automatic logic [127:0] get_rd(input int d);
    case (d)
      0: return {64'b0, rd0};
      1: return {83'b0, rd1};
      default: return {112'b0, rd2};
    endcase
  endfunction

  function automatic logic [127:0] exp_rd(input int d, input int a);
    logic [127:0] m;
    m = '1;
    m = m >> (128 - dw(d));
    if (a >= nw(d)) return '0;
    return mem[d][a] & m;
  endfunction

  task automatic model_wr(input int d, input int a, input logic [15:0] b, input logic [127:0] data);
    if (a < nw(d)) begin
      for (int i = 0; i < dw(d); i++) begin
        if (b[i/8]) mem[d][a][i] = data[i];
      end
    end
  endtask

  task automatic model_zero(input int d);
    for (int a = 0; a < 1024; a++) mem[d][a] = '0;
  endtask

  // One request per clock; returns with outputs of the following cycle settled.
  task automatic drive(input int d, input logic c, input logic w, input logic [15:0] b,
                       input logic [127:0] data, input int a);
    cs[d] = c; we[d] = w; be[d] = b; wd[d] = data; ad[d] = a[9:0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 1'b0, 16'h0, '0, 0);
  endtask

  task automatic wr_req(input int d, input int a, input logic [15:0] b, input logic [127:0] data,
                        output logic e);
    drive(d, 1'b1, 1'b1, b, data, a);
    model_wr(d, a, b, data);
    e = err[d];
  endtask

  task automatic rd_req(input int d, input int a, output logic v, output logic [127:0] data,
                        output logic e);
    drive(d, 1'b1, 1'b0, 16'h0, '0, a);
    v = vld[d];
    data = get_rd(d);
    e = err[d];
  endtask

  task automatic run_init(input int d, output int n, output int nd, output logic dn);
    rst[d] = 1'b0;
    cs[d] = 1'b0;
    #1;
    n = 0;
    nd = 0;
    while (!rdy[d] && n < 600) begin
      if (done[d]) nd++;
      n++;
      idle(d);
    end
    dn = done[d];
  endtask

  task automatic test_reset();
    rst = '1;
    for (int k = 0; k < 4; k++) begin
      cs = '1; we = '0; ad[0] = 10'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({rdy[d], vld[d], err[d], done[d]} !== 4'b0) begin
        failures++;
        $display("FAIL reset_ctrl d%0d: rdy/vld/err/done=%b expected 0000", d,
                 {rdy[d], vld[d], err[d], done[d]});
      end
      checks++;
      if (get_rd(d) !== 128'h0) begin
        failures++;
        $display("FAIL reset_data d%0d: got %h expected 0", d, get_rd(d));
      end
    end
    cs = '0;
  endtask

  task automatic test_init_restart();
    int n, nd, nv;
    logic dn, v, e;
    logic [127:0] r;
    rst[0] = 1'b0;
    #1;
    nv = 0;
    for (int k = 0; k < 100; k++) begin
      drive(0, (k % 3) == 0, 1'($urandom_range(0, 1)), 16'hFF, 128'($urandom), $urandom_range(0, 255));
      if (vld[0] || rdy[0]) nv++;
    end
    checks++;
    if (nv != 0) begin
      failures++;
      $display("FAIL init_csel_ignored: %0d cycles with vld/rdy, expected 0", nv);
    end
    rst[0] = 1'b1;
    idle(0);
    idle(0);
    run_init(0, n, nd, dn);
    checks++;
    if (n != 256) begin
      failures++;
      $display("FAIL init_restart_len: got %0d cycles expected 256", n);
    end
    checks++;
    if (nd != 0 || dn !== 1'b1) begin
      failures++;
      $display("FAIL init_done_pulse: early=%0d at_ready=%b expected 0/1", nd, dn);
    end
    idle(0);
    checks++;
    if (done[0] !== 1'b0) begin
      failures++;
      $display("FAIL init_done_single: got %b expected 0", done[0]);
    end
    model_zero(0);
    rd_req(0, 8'h7F, v, r, e);
    checks++;
    if (v !== 1'b1 || r !== exp_rd(0, 8'h7F)) begin
      failures++;
      $display("FAIL init_read_7f: vld=%b data=%h expected 1/%h", v, r, exp_rd(0, 8'h7F));
    end
    idle(0);
  endtask

  task automatic test_init_banked();
    int n, nd;
    logic dn;
    run_init(1, n, nd, dn);
    checks++;
    if (n != 256 || nd != 0 || dn !== 1'b1) begin
      failures++;
      $display("FAIL init_d1: cycles=%0d early=%0d done=%b expected 256/0/1", n, nd, dn);
    end
    model_zero(1);
  endtask

  task automatic test_byte_enable();
    logic e, v;
    logic [127:0] r;
    wr_req(0, 5, 16'hFF, 128'h0123456789ABCDEF, e);
    checks++;
    if (vld[0] !== 1'b0) begin
      failures++;
      $display("FAIL be_write_novld: got %b expected 0", vld[0]);
    end
    wr_req(0, 5, 16'h0F, 128'hFFFFFFFFFFFFFFFF, e);
    wr_req(0, 6, 16'h00, 128'hDEADBEEF, e);
    rd_req(0, 5, v, r, e);
    checks++;
    if (v !== 1'b1 || r !== 128'h01234567FFFFFFFF) begin
      failures++;
      $display("FAIL be_merge: vld=%b data=%h expected 1/01234567ffffffff", v, r);
    end
    rd_req(0, 6, v, r, e);
    checks++;
    if (r !== 128'h0) begin
      failures++;
      $display("FAIL be_zero_noop: got %h expected 0", r);
    end
    idle(0);
    checks++;
    if (vld[0] !== 1'b0) begin
      failures++;
      $display("FAIL rdvalid_pulse_width: got %b expected 0", vld[0]);
    end
  endtask

  task automatic test_hold();
    logic e, v;
    logic [127:0] r, held;
    int bad;
    wr_req(0, 9, 16'hFF, 128'h1122334455667788, e);
    rd_req(0, 9, v, held, e);
    checks++;
    if (held !== exp_rd(0, 9)) begin
      failures++;
      $display("FAIL hold_first_read: got %h expected %h", held, exp_rd(0, 9));
    end
    bad = 0;
    idle(0);
    if (vld[0] !== 1'b0 || get_rd(0) !== held) bad++;
    wr_req(0, 9, 16'hFF, 128'h99AABBCCDDEEFF00, e);
    if (vld[0] !== 1'b0 || get_rd(0) !== held) bad++;
    idle(0);
    if (vld[0] !== 1'b0 || get_rd(0) !== held) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable: %0d cycles changed, expected 0", bad);
    end
    rd_req(0, 9, v, r, e);
    checks++;
    if (r !== exp_rd(0, 9)) begin
      failures++;
      $display("FAIL hold_raw: got %h expected %h", r, exp_rd(0, 9));
    end
    idle(0);
  endtask

  task automatic test_random();
    logic e, v;
    logic [127:0] r;
    int a, bad;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) begin
        wr_req(0, a, 16'($urandom), {$urandom, $urandom}, e);
        if (vld[0] !== 1'b0) bad++;
        if ($urandom_range(0, 1) == 1) begin
          rd_req(0, a, v, r, e);
          if (v !== 1'b1 || r !== exp_rd(0, a)) bad++;
        end
      end else begin
        rd_req(0, a, v, r, e);
        if (v !== 1'b1 || r !== exp_rd(0, a) || e !== 1'b0) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL random_d0: %0d mismatching responses, expected 0", bad);
    end
    idle(0);
  endtask

  task automatic test_banks();
    logic e, v;
    logic [127:0] r;
    int a, bad;
    wr_req(1, 300, 16'h3F, 128'h1FFFFFFFFFFF, e);
    wr_req(1, 44,  16'h3F, 128'h0AAAAAAAAAAA, e);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      a = (k % 2 == 0) ? 300 : 44;
      rd_req(1, a, v, r, e);
      if (v !== 1'b1 || r !== ((a == 300) ? 128'h1FFFFFFFFFFF : 128'h0AAAAAAAAAAA)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bank_alternate: %0d bad reads, expected 0", bad);
    end
    for (int k = 0; k < 60; k++) begin
      wr_req(1, $urandom_range(0, 1023), 16'($urandom), {$urandom, $urandom}, e);
    end
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      a = $urandom_range(0, 1023);
      rd_req(1, a, v, r, e);
      if (v !== 1'b1 || r !== exp_rd(1, a) || e !== (a >= 768)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bank_random: %0d bad reads, expected 0", bad);
    end
    idle(1);
  endtask

  task automatic test_oor();
    logic e, v;
    logic [127:0] r;
    int bad;
    rd_req(1, 800, v, r, e);
    checks++;
    if (v !== 1'b1 || r !== 128'h0 || e !== 1'b1) begin
      failures++;
      $display("FAIL oor_read: vld=%b data=%h err=%b expected 1/0/1", v, r, e);
    end
    idle(1);
    checks++;
    if (err[1] !== 1'b0) begin
      failures++;
      $display("FAIL oor_err_pulse: got %b expected 0", err[1]);
    end
    wr_req(1, 800, 16'h3F, 128'h15555_5555_5555, e);
    checks++;
    if (e !== 1'b1 || vld[1] !== 1'b0) begin
      failures++;
      $display("FAIL oor_write: err=%b vld=%b expected 1/0", e, vld[1]);
    end
    bad = 0;
    for (int a = 0; a < 768; a++) begin
      rd_req(1, a, v, r, e);
      if (v !== 1'b1 || r !== exp_rd(1, a)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL oor_scan: %0d words differ, expected 0", bad);
    end
    idle(1);
  endtask

  task automatic test_midread_reset();
    logic e, v;
    logic [127:0] r;
    int n, nd;
    logic dn;
    wr_req(0, 200, 16'hFF, 128'hCAFEF00D12345678, e);
    drive(0, 1'b1, 1'b0, 16'h0, '0, 200);
    rst[0] = 1'b1;
    cs[0] = 1'b0;
    #1;
    checks++;
    if (vld[0] !== 1'b0 || get_rd(0) !== 128'h0 || rdy[0] !== 1'b0) begin
      failures++;
      $display("FAIL midread_reset: vld=%b rdy=%b data=%h expected 0/0/0", vld[0], rdy[0], get_rd(0));
    end
    idle(0);
    run_init(0, n, nd, dn);
    checks++;
    if (n != 256 || dn !== 1'b1) begin
      failures++;
      $display("FAIL midread_reinit: cycles=%0d done=%b expected 256/1", n, dn);
    end
    model_zero(0);
    rd_req(0, 200, v, r, e);
    checks++;
    if (v !== 1'b1 || r !== exp_rd(0, 200)) begin
      failures++;
      $display("FAIL reinit_cleared: vld=%b data=%h expected 1/%h", v, r, exp_rd(0, 200));
    end
    idle(0);
  endtask

  task automatic test_no_init();
    logic e, v;
    logic [127:0] r;
    int a [4];
    int bad;
    rst[2] = 1'b0;
    #1;
    checks++;
    if (rdy[2] !== 1'b1 || done[2] !== 1'b1) begin
      failures++;
      $display("FAIL noinit_first: rdy=%b done=%b expected 1/1", rdy[2], done[2]);
    end
    idle(2);
    checks++;
    if (done[2] !== 1'b0) begin
      failures++;
      $display("FAIL noinit_done_once: got %b expected 0", done[2]);
    end
    for (int k = 0; k < 4; k++) begin
      a[k] = 128 * k + $urandom_range(0, 127);
      wr_req(2, a[k], 16'h3, 128'($urandom), e);
    end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      rd_req(2, a[k], v, r, e);
      if (v !== 1'b1 || r !== exp_rd(2, a[k])) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL noinit_rw: %0d bad reads, expected 0", bad);
    end
    idle(2);
  endtask

  initial begin
    rst = '1; cs = '0; we = '0; be = '0; wd = '0; ad = '0;
    for (int d = 0; d < 3; d++) model_zero(d);
    @(posedge clk);
    #1;
    test_reset();
    test_init_restart();
    test_init_banked();
    test_byte_enable();
    test_hold();
    test_random();
    test_banks();
    test_oor();
    test_midread_reset();
    test_no_init();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
